ddr4_axi_cmd_splitter: RTL and testbench



---
 rtl/ddr4_axi_cmd_splitter.sv | 116 +++++++++++
 tb/tb_ddr4_axi_cmd_splitter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr4_axi_cmd_splitter.sv
`default_nettype none
// ============================================================================
// Module   : ddr4_axi_cmd_splitter
// Brief    : Splits one AXI burst into MC-burst-aligned command byte addresses,
//            advancing one address per `next` pulse from the command FSM.
// Revision : 1.0 - initial release
// ============================================================================
module ddr4_axi_cmd_splitter #(
    parameter int C_AXI_ADDR_WIDTH = 32,
    parameter int C_DATA_WIDTH     = 128,
    parameter int C_MC_BURST_LEN   = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [C_AXI_ADDR_WIDTH-1:0] axaddr,
    input  logic [7:0]                  axlen,
    input  logic [2:0]                  axsize,
    input  logic [1:0]                  axburst,
    input  logic                        next,
    output logic [C_AXI_ADDR_WIDTH-1:0] cmd_byte_addr,
    output logic                        next_pending
);

    localparam int C_MC_BYTES = C_MC_BURST_LEN * C_DATA_WIDTH / 8;
    localparam int C_MC_SHIFT = $clog2(C_MC_BYTES);
    localparam logic [2:0] C_MAX_SIZE = 3'($clog2(C_DATA_WIDTH / 8));
    localparam logic [C_AXI_ADDR_WIDTH-1:0] C_MC_MASK = C_AXI_ADDR_WIDTH'(C_MC_BYTES - 1);
    localparam logic [C_AXI_ADDR_WIDTH-1:0] C_MC_STEP = C_AXI_ADDR_WIDTH'(C_MC_BYTES);

    localparam logic [1:0] C_BURST_FIXED = 2'd0;
    localparam logic [1:0] C_BURST_WRAP  = 2'd2;

    localparam logic [0:0] C_ST_BURST = 1'b0;
    localparam logic [0:0] C_ST_FIRST = 1'b1;

    logic [0:0]                  r_state;
    logic [C_AXI_ADDR_WIDTH-1:0] r_addr;
    logic [8:0]                  r_remain;
    logic [1:0]                  r_burst;
    logic [C_AXI_ADDR_WIDTH-1:0] r_wmask;

    logic [12:0]                 w_total;
    logic [15:0]                 w_span;
    logic [C_AXI_ADDR_WIDTH-1:0] w_abase;
    logic [C_AXI_ADDR_WIDTH-1:0] w_wmask_in;
    logic [15:0]                 w_n;
    logic                        w_first;

    function automatic logic [C_AXI_ADDR_WIDTH-1:0] f_advance(
        input logic [C_AXI_ADDR_WIDTH-1:0] a,
        input logic [1:0]                  burst,
        input logic [C_AXI_ADDR_WIDTH-1:0] wmask
    );
        logic [C_AXI_ADDR_WIDTH-1:0] inc;
        inc = a + C_MC_STEP;
        case (burst)
            C_BURST_FIXED: f_advance = a;
            C_BURST_WRAP:  f_advance = (a & ~wmask) | (inc & wmask);
            default:       f_advance = inc;
        endcase
    endfunction

    // Byte span of the burst and the number of MC commands needed to cover it.
    always_comb begin
        w_total    = (13'(axlen) + 13'd1) << axsize;
        w_abase    = axaddr & ~C_MC_MASK;
        w_wmask_in = C_AXI_ADDR_WIDTH'(w_total - 13'd1);
        w_span     = 16'(axaddr & C_MC_MASK) + 16'(w_total) - 16'd1;
        case (axburst)
            C_BURST_FIXED: w_n = 16'(axlen) + 16'd1;
            C_BURST_WRAP:  w_n = (w_total <= 13'(C_MC_BYTES)) ? 16'd1
                                                              : 16'(w_total >> C_MC_SHIFT);
            default:       w_n = (w_span >> C_MC_SHIFT) + 16'd1;
        endcase
    end

    assign w_first       = (r_state == C_ST_FIRST);
    assign cmd_byte_addr = w_first ? w_abase : r_addr;
    assign next_pending  = w_first ? (w_n > 16'd1) : (r_remain != 9'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= C_ST_FIRST;
            r_addr   <= '0;
            r_remain <= '0;
            r_burst  <= '0;
            r_wmask  <= '0;
        end else if (next) begin
            if (w_first) begin
                if (w_n > 16'd1) begin
                    r_addr   <= f_advance(w_abase, axburst, w_wmask_in);
                    r_remain <= 9'(w_n - 16'd2);
                    r_burst  <= axburst;
                    r_wmask  <= w_wmask_in;
                    r_state  <= C_ST_BURST;
                end
            end else if (r_remain != 9'd0) begin
                r_addr   <= f_advance(r_addr, r_burst, r_wmask);
                r_remain <= r_remain - 9'd1;
            end else begin
                r_state <= C_ST_FIRST;
            end
        end
    end

`ifndef SYNTHESIS
    logic w_illegal;
    assign w_illegal = (axsize > C_MAX_SIZE) ||
                       ((axburst == C_BURST_WRAP) && !(axlen inside {8'd1, 8'd3, 8'd7, 8'd15}));

    a_legal_burst: assert property (@(posedge clk) disable iff (reset)
        (w_first && next) |-> !w_illegal);
`endif

endmodule
`default_nettype wire

// File: tb/tb_ddr4_axi_cmd_splitter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ddr4_axi_cmd_splitter
// Brief    : Self-checking bench for ddr4_axi_cmd_splitter against an
//            address-list reference model (MC_BYTES = 16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ddr4_axi_cmd_splitter;

    logic        clk;
    logic        reset;
    logic [31:0] axaddr;
    logic [7:0]  axlen;
    logic [2:0]  axsize;
    logic [1:0]  axburst;
    logic        next;
    logic [31:0] cmd_byte_addr;
    logic        next_pending;

    int n_checks;
    int n_fail;
    logic [31:0] exp_q[$];

    ddr4_axi_cmd_splitter #(
        .C_AXI_ADDR_WIDTH (32),
        .C_DATA_WIDTH     (128),
        .C_MC_BURST_LEN   (1)
    ) u_dut (
        .clk           (clk),
        .reset         (reset),
        .axaddr        (axaddr),
        .axlen         (axlen),
        .axsize        (axsize),
        .axburst       (axburst),
        .next          (next),
        .cmd_byte_addr (cmd_byte_addr),
        .next_pending  (next_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: list every 16-byte block the burst touches, in issue order.
    task automatic build_model(input logic [31:0] a, input logic [7:0] len,
                               input logic [2:0] size, input logic [1:0] burst);
        longint total;
        longint lo;
        longint abase;
        total = (longint'(len) + 1) << size;
        abase = longint'(a) - (longint'(a) % 16);
        exp_q.delete();
        if (burst == 2'd0) begin
            for (int k = 0; k <= int'(len); k++) exp_q.push_back(32'(abase));
        end else if (burst == 2'd2) begin
            if (total <= 16) begin
                exp_q.push_back(32'(abase));
            end else begin
                lo = longint'(a) - (longint'(a) % total);
                for (longint k = 0; k < total / 16; k++)
                    exp_q.push_back(32'(lo + ((abase - lo + k * 16) % total)));
            end
        end else begin
            for (longint b = longint'(a) / 16; b <= (longint'(a) + total - 1) / 16; b++)
                exp_q.push_back(32'(b * 16));
        end
    endtask

    task automatic apply_burst(input logic [31:0] a, input logic [7:0] len,
                               input logic [2:0] size, input logic [1:0] burst);
        axaddr  = a;
        axlen   = len;
        axsize  = size;
        axburst = burst;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        next  = 1'b0;
        apply_burst(32'h1234_5678, 8'd3, 3'd4, 2'd1);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #1;
        n_checks++;
        if (cmd_byte_addr !== 32'h1234_5670) begin
            n_fail++;
            $display("FAIL reset_addr: got %h want %h", cmd_byte_addr, 32'h1234_5670);
        end
        n_checks++;
        if (next_pending !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_pending: got %b want 1", next_pending);
        end
    endtask

    task automatic test_incr();
        logic [31:0] t_addr[4] = '{32'h0000_1000, 32'h0000_1008, 32'h0000_2004, 32'hFFFF_FFF0};
        logic [7:0]  t_len[4]  = '{8'd3, 8'd1, 8'd7, 8'd1};
        logic [2:0]  t_size[4] = '{3'd4, 3'd4, 3'd2, 3'd4};
        for (int t = 0; t < 4; t++) begin
            build_model(t_addr[t], t_len[t], t_size[t], 2'd1);
            @(negedge clk);
            apply_burst(t_addr[t], t_len[t], t_size[t], 2'd1);
            for (int i = 0; i < exp_q.size(); i++) begin
                #1;
                n_checks++;
                if (cmd_byte_addr !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL incr_addr case %0d cmd %0d: got %h want %h", t, i, cmd_byte_addr, exp_q[i]);
                end
                n_checks++;
                if (next_pending !== logic'(i != exp_q.size() - 1)) begin
                    n_fail++;
                    $display("FAIL incr_pending case %0d cmd %0d: got %b", t, i, next_pending);
                end
                next = 1'b1;
                @(negedge clk);
            end
            next = 1'b0;
            #1;
            n_checks++;
            if (cmd_byte_addr !== exp_q[0]) begin
                n_fail++;
                $display("FAIL incr_return_first case %0d: got %h want %h", t, cmd_byte_addr, exp_q[0]);
            end
        end
    endtask

    task automatic test_wrap_fixed();
        logic [31:0] t_addr[3]  = '{32'h0000_3030, 32'h0000_4018, 32'h0000_3034};
        logic [7:0]  t_len[3]   = '{8'd3, 8'd2, 8'd1};
        logic [2:0]  t_size[3]  = '{3'd4, 3'd4, 3'd2};
        logic [1:0]  t_burst[3] = '{2'd2, 2'd0, 2'd2};
        for (int t = 0; t < 3; t++) begin
            build_model(t_addr[t], t_len[t], t_size[t], t_burst[t]);
            @(negedge clk);
            apply_burst(t_addr[t], t_len[t], t_size[t], t_burst[t]);
            for (int i = 0; i < exp_q.size(); i++) begin
                #1;
                n_checks++;
                if (cmd_byte_addr !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL wf_addr case %0d cmd %0d: got %h want %h", t, i, cmd_byte_addr, exp_q[i]);
                end
                n_checks++;
                if (next_pending !== logic'(i != exp_q.size() - 1)) begin
                    n_fail++;
                    $display("FAIL wf_pending case %0d cmd %0d: got %b", t, i, next_pending);
                end
                next = 1'b1;
                @(negedge clk);
            end
            next = 1'b0;
        end
    endtask

    task automatic test_stall();
        int i;
        int stall_left;
        build_model(32'h0000_5000, 8'd3, 3'd4, 2'd1);
        @(negedge clk);
        apply_burst(32'h0000_5000, 8'd3, 3'd4, 2'd1);
        i = 0;
        stall_left = 5;
        while (i < exp_q.size()) begin
            #1;
            n_checks++;
            if (cmd_byte_addr !== exp_q[i]) begin
                n_fail++;
                $display("FAIL stall_addr cmd %0d: got %h want %h", i, cmd_byte_addr, exp_q[i]);
            end
            n_checks++;
            if (next_pending !== logic'(i != exp_q.size() - 1)) begin
                n_fail++;
                $display("FAIL stall_pending cmd %0d: got %b", i, next_pending);
            end
            next = !(i == 1 && stall_left > 0);
            @(negedge clk);
            if (next) i++;
            else stall_left--;
        end
        next = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        @(negedge clk);
        apply_burst(32'h0000_7000, 8'd3, 3'd4, 2'd1);
        next = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (cmd_byte_addr !== 32'h0000_7020) begin
            n_fail++;
            $display("FAIL midrst_pre: got %h want %h", cmd_byte_addr, 32'h0000_7020);
        end
        reset = 1'b1;
        apply_burst(32'h0000_6000, 8'd0, 3'd4, 2'd1);
        @(negedge clk);
        reset = 1'b0;
        next  = 1'b0;
        #1;
        n_checks++;
        if (cmd_byte_addr !== 32'h0000_6000 || next_pending !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_post: got %h/%b want 00006000/0", cmd_byte_addr, next_pending);
        end
        next = 1'b1;
        @(negedge clk);
        next = 1'b0;
        #1;
        n_checks++;
        if (cmd_byte_addr !== 32'h0000_6000 || next_pending !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_single: got %h/%b want 00006000/0", cmd_byte_addr, next_pending);
        end
    endtask

    task automatic test_random();
        logic [7:0]  wrap_lens[4] = '{8'd1, 8'd3, 8'd7, 8'd15};
        logic [31:0] a;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        int          i;
        logic        stall;
        for (int t = 0; t < 40; t++) begin
            a     = $urandom;
            size  = 3'($urandom_range(0, 4));
            burst = 2'($urandom_range(0, 3));
            len   = (burst == 2'd2) ? wrap_lens[$urandom_range(0, 3)]
                  : ((t % 10 == 0) ? 8'd255 : 8'($urandom_range(0, 31)));
            build_model(a, len, size, burst);
            @(negedge clk);
            apply_burst(a, len, size, burst);
            i = 0;
            while (i < exp_q.size()) begin
                #1;
                n_checks++;
                if (cmd_byte_addr !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL rand_addr burst %0d cmd %0d: got %h want %h", t, i, cmd_byte_addr, exp_q[i]);
                end
                n_checks++;
                if (next_pending !== logic'(i != exp_q.size() - 1)) begin
                    n_fail++;
                    $display("FAIL rand_pending burst %0d cmd %0d: got %b", t, i, next_pending);
                end
                stall = ($urandom_range(0, 3) == 0);
                next  = !stall;
                @(negedge clk);
                if (!stall) i++;
            end
            next = 1'b0;
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        next     = 1'b0;
        apply_burst(32'h0, 8'd0, 3'd4, 2'd1);
        test_reset();
        test_incr();
        test_wrap_fixed();
        test_stall();
        test_reset_mid_burst();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
